// File: rtl/game_2048_pkg.sv
// game_2048_pkg: shared types and codes for the 2048 controller slice.
// rev 1.0
`default_nettype none

package game_2048_pkg;

  localparam int TILE_W = 12;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  localparam logic [1:0] WL_PLAY = 2'b00;
  localparam logic [1:0] WL_WIN  = 2'b01;
  localparam logic [1:0] WL_LOSE = 2'b10;

  localparam logic [1:0] SO_IDLE = 2'b00;
  localparam logic [1:0] SO_PLAY = 2'b01;
  localparam logic [1:0] SO_WON  = 2'b10;
  localparam logic [1:0] SO_LOST = 2'b11;

  typedef logic [3:0][3:0][TILE_W-1:0] board_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_BTN,
    S_ISSUE,
    S_WAIT,
    S_COMMIT,
    S_SPAWN,
    S_CHECK,
    S_WON,
    S_LOST
  } ctrl_state_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_2048_controller_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1.
// rev 1.0
`default_nettype none

module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= SEED;
    else     q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
  end

endmodule

`default_nettype wire

// File: rtl/game_2048_controller.sv
// game_2048_controller: sequences moves to game_logic, owns the board, spawns tiles.
// rev 1.0
`default_nettype none

module game_2048_controller #(
  parameter int          TILE_W    = 12,
  parameter int          LOGIC_LAT = 2,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [3:0]                   btn,
  input  logic [3:0]                   goal_sel,
  input  logic [3:0][3:0][TILE_W-1:0]  matrix_D,
  input  logic [1:0]                   wl,
  output logic                         enable,
  output logic [3:0]                   direction,
  output logic [3:0]                   goal,
  output logic [3:0][3:0][TILE_W-1:0]  matrix,
  output logic [1:0]                   state_o
);

  import game_2048_pkg::*;

  localparam logic [7:0] WAIT_LAST = 8'(LOGIC_LAT - 1);

  ctrl_state_t       state;
  logic [15:0]       lfsr;
  logic [3:0]        btn_q;
  logic [3:0]        rise;
  logic              press_ok;
  logic [3:0]        probe_idx;
  logic [3:0]        probe_cnt;
  logic [1:0]        spawn_cnt;
  logic [1:0]        wl_q;
  logic [7:0]        wait_cnt;
  logic [TILE_W-1:0] probe_cell;
  logic [TILE_W-1:0] new_tile;
  logic              unused_lfsr_hi;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign rise           = btn & ~btn_q;
  assign press_ok       = is_onehot4(rise);
  assign probe_cell     = matrix[probe_idx[3:2]][probe_idx[1:0]];
  assign new_tile       = (lfsr[7:4] == 4'hF) ? TILE_W'(4) : TILE_W'(2);
  assign unused_lfsr_hi = ^lfsr[15:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      enable    <= 1'b0;
      direction <= DIR_NONE;
      goal      <= 4'd0;
      matrix    <= '0;
      state_o   <= SO_IDLE;
      btn_q     <= 4'd0;
      probe_idx <= 4'd0;
      probe_cnt <= 4'd0;
      spawn_cnt <= 2'd0;
      wl_q      <= WL_PLAY;
      wait_cnt  <= 8'd0;
    end else begin
      btn_q  <= btn;
      enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_INIT;
            state_o <= SO_PLAY;
          end
        end
        S_INIT: begin
          matrix    <= '0;
          goal      <= goal_sel;
          wl_q      <= WL_PLAY;
          spawn_cnt <= 2'd2;
          probe_idx <= lfsr[3:0];
          probe_cnt <= 4'd0;
          state     <= S_SPAWN;
        end
        S_WAIT_BTN: begin
          if (press_ok) begin
            direction <= rise;
            enable    <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= 8'd0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= S_COMMIT;
          else                       wait_cnt <= wait_cnt + 8'd1;
        end
        S_COMMIT: begin
          direction <= DIR_NONE;
          wl_q      <= wl;
          if (matrix_D != matrix) begin
            matrix    <= matrix_D;
            spawn_cnt <= 2'd1;
            probe_idx <= lfsr[3:0];
            probe_cnt <= 4'd0;
            state     <= S_SPAWN;
          end else begin
            state <= S_CHECK;
          end
        end
        // Each placed tile re-seeds the probe start from the LFSR.
        S_SPAWN: begin
          if (probe_cell == '0) begin
            matrix[probe_idx[3:2]][probe_idx[1:0]] <= new_tile;
            if (spawn_cnt == 2'd1) begin
              state <= S_CHECK;
            end else begin
              spawn_cnt <= spawn_cnt - 2'd1;
              probe_idx <= lfsr[3:0];
              probe_cnt <= 4'd0;
            end
          end else if (probe_cnt == 4'd15) begin
            state <= S_CHECK;
          end else begin
            probe_idx <= probe_idx + 4'd1;
            probe_cnt <= probe_cnt + 4'd1;
          end
        end
        S_CHECK: begin
          case (wl_q)
            WL_WIN: begin
              state   <= S_WON;
              state_o <= SO_WON;
            end
            WL_LOSE: begin
              state   <= S_LOST;
              state_o <= SO_LOST;
            end
            default: state <= S_WAIT_BTN;
          endcase
        end
        S_WON, S_LOST: begin
          if (start) begin
            state   <= S_INIT;
            state_o <= SO_PLAY;
          end
        end
        default: begin
          state   <= S_IDLE;
          state_o <= SO_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_game_2048_controller.sv
// tb_game_2048_controller: scoreboard bench with a stubbed game_logic driven from the bench.
// rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_game_2048_controller;
  import game_2048_pkg::*;

  localparam int          LAT    = 2;
  localparam logic [15:0] SEED_V = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  btn;
  logic [3:0]  goal_sel;
  board_t      matrix_D;
  logic [1:0]  wl;
  logic        enable;
  logic [3:0]  direction;
  logic [3:0]  goal;
  board_t      matrix;
  logic [1:0]  state_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_lfsr;
  logic [15:0] lhist[$];
  logic [3:0]  sb[$];
  int          en_cnt = 0;
  int          en_idx = 0;

  always #5 clk = ~clk;

  game_2048_controller #(.TILE_W(TILE_W), .LOGIC_LAT(LAT), .SEED(SEED_V)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .btn       (btn),
    .goal_sel  (goal_sel),
    .matrix_D  (matrix_D),
    .wl        (wl),
    .enable    (enable),
    .direction (direction),
    .goal      (goal),
    .matrix    (matrix),
    .state_o   (state_o)
  );

  // Reference LFSR running in lockstep with the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED_V;
    else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic check_val(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every sample point records the LFSR and drains the enable scoreboard.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      lhist.push_back(m_lfsr);
      if (enable) begin
        en_cnt++;
        en_idx = lhist.size() - 1;
        check_val("enable_expected", (sb.size() > 0), 1);
        if (sb.size() > 0) check_val("enable_dir", direction, sb.pop_front());
      end
    end
  endtask

  function automatic board_t spawn_model(input board_t b, input int cnt, input int t);
    logic [15:0] l;
    int idx;
    int n;
    board_t r;
    r = b;
    if (t >= lhist.size()) return r;
    l   = lhist[t];
    idx = int'(l[3:0]);
    t++;
    n = 0;
    while (cnt > 0 && n < 16 && t < lhist.size()) begin
      l = lhist[t];
      if (r[idx/4][idx%4] == '0) begin
        r[idx/4][idx%4] = (l[7:4] == 4'hF) ? 12'd4 : 12'd2;
        cnt--;
        idx = int'(l[3:0]);
        n = 0;
      end else begin
        idx = (idx + 1) % 16;
        n++;
      end
      t++;
    end
    return r;
  endfunction

  function automatic int count_diff(input board_t a, input board_t b);
    int c;
    c = 0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (a[r][k] != b[r][k]) c++;
    return c;
  endfunction

  task automatic start_game(output int t_init);
    t_init = -1;
    start  = 1'b1;
    for (int k = 0; k < 5 && t_init < 0; k++) begin
      step();
      if (state_o == SO_PLAY) t_init = lhist.size() - 1;
    end
    start = 1'b0;
    check_val("start_state", state_o, SO_PLAY);
    if (t_init < 0) t_init = lhist.size() - 1;
  endtask

  task automatic press(input logic [3:0] b, input logic expect_en);
    btn = b;
    if (expect_en) sb.push_back(b);
    step();
    btn = 4'b0000;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    board_t p1, p2, p3, exp_b;
    int     t0, e0;

    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        p1[r][k] = ((r + k) % 3 == 0) ? 12'd0 : 12'(1 << ((r + k) % 4 + 1));
        p3[r][k] = 12'(2 << ((r * 4 + k) % 5));
      end
    p2       = p1;
    p2[0][1] = 12'h800;

    rst = 1'b1; start = 1'b0; btn = 4'b0000; goal_sel = 4'hB; matrix_D = '0; wl = WL_PLAY;
    step(3);
    check_val("rst_enable", enable, 0);
    check_val("rst_direction", direction, DIR_NONE);
    check_val("rst_goal", goal, 0);
    check_val("rst_matrix", matrix, 0);
    check_val("rst_state", state_o, SO_IDLE);
    rst = 1'b0;
    step(2);

    // New game: two tiles at LFSR-predicted cells.
    start_game(t0);
    step(22);
    exp_b = spawn_model('0, 2, t0);
    check_val("init_board", matrix, exp_b);
    check_val("init_tile_count", count_diff(matrix, '0), 2);
    check_val("init_goal", goal, 4'hB);

    // Changing move: board committed plus one spawned tile.
    matrix_D = p1; wl = WL_PLAY; e0 = en_cnt;
    press(DIR_LEFT, 1'b1);
    step(25);
    check_val("move_enable_count", en_cnt - e0, 1);
    exp_b = spawn_model(p1, 1, en_idx + LAT + 1);
    check_val("move_board", matrix, exp_b);
    check_val("move_one_new_tile", count_diff(matrix, p1), 1);

    // No-op move: nothing spawns.
    matrix_D = exp_b; e0 = en_cnt;
    press(DIR_UP, 1'b1);
    step(15);
    check_val("noop_enable_count", en_cnt - e0, 1);
    check_val("noop_board", matrix, exp_b);
    check_val("noop_state", state_o, SO_PLAY);

    // Winning move, then frozen board.
    matrix_D = p2; wl = WL_WIN;
    press(DIR_RIGHT, 1'b1);
    step(25);
    exp_b = spawn_model(p2, 1, en_idx + LAT + 1);
    check_val("win_board", matrix, exp_b);
    check_val("win_state", state_o, SO_WON);
    e0 = en_cnt;
    press(DIR_DOWN, 1'b0);
    step(10);
    check_val("won_no_enable", en_cnt - e0, 0);
    check_val("won_frozen", matrix, exp_b);
    wl = WL_PLAY;
    start_game(t0);
    step(22);
    check_val("restart_board", matrix, spawn_model('0, 2, t0));

    // Full board after the move: spawn aborts, then loss.
    matrix_D = p3; wl = WL_LOSE;
    press(DIR_RIGHT, 1'b1);
    step(30);
    check_val("full_board", matrix, p3);
    check_val("lose_state", state_o, SO_LOST);

    // Reset while enable is high must drop it without a clock edge.
    wl = WL_PLAY;
    start_game(t0);
    step(22);
    matrix_D = p1;
    btn = DIR_LEFT;
    sb.push_back(DIR_LEFT);
    e0 = en_cnt;
    step();
    check_val("pre_rst_enable", en_cnt - e0, 1);
    #1 rst = 1'b1;
    #1;
    check_val("async_rst_enable", enable, 0);
    check_val("async_rst_direction", direction, DIR_NONE);
    check_val("async_rst_matrix", matrix, 0);
    check_val("async_rst_state", state_o, SO_IDLE);
    check_val("async_rst_goal", goal, 0);
    btn = 4'b0000;
    step(2);
    rst = 1'b0;
    step();

    // Two-bit rise is not a press; a following single press still works.
    start_game(t0);
    step(22);
    exp_b = spawn_model('0, 2, t0);
    check_val("post_rst_board", matrix, exp_b);
    e0 = en_cnt;
    press(4'b0011, 1'b0);
    step(10);
    check_val("multibit_no_enable", en_cnt - e0, 0);
    matrix_D = exp_b;
    press(DIR_DOWN, 1'b1);
    step(10);
    check_val("single_after_multi", en_cnt - e0, 1);
    check_val("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/game_2048_controller.md
Name: game_2048_controller

Overview:
- Sequencing master for `game_logic`: drives it and consumes its results.
- Turns debounced button presses into one-cycle move commands (`enable`, `direction`) and presents the current board on `matrix`.
- After the fixed logic latency, samples `matrix_D` and `wl`, commits the new board and spawns a random tile when the move changed the board.
- Holds the authoritative board register; the board output feeds the VGA/display path.

Parameters:
- `TILE_W`, 12, bit width of one tile value.
- `LOGIC_LAT`, 2, clock cycles from the `enable` pulse until `matrix_D`/`wl` are valid.
- `SEED`, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `start`  in  1  level; starts a new game from IDLE/WON/LOST
- `btn`  in  4  debounced buttons {right,left,down,up}
- `goal_sel`  in  4  goal exponent; passed through
- `matrix_D`  in  TILE_W x4x4  board result from `game_logic`
- `wl`  in  2  00 playing, 01 win, 10 lose, 11 reserved (treated as 00)
- `enable`  out  1  one-cycle move strobe to `game_logic`
- `direction`  out  4  one-hot: 0001 up, 0010 down, 0100 left, 1000 right; 0000 idle
- `goal`  out  4  registered `goal_sel`, latched in INIT
- `matrix`  out  TILE_W x4x4  board register (to `game_logic` and display)
- `state_o`  out  2  00 idle, 01 playing, 10 won, 11 lost

Behaviour:
- Reset values:
  - state IDLE
  - `enable`=0, `direction`=0000, `goal`=0
  - `matrix` all 0, `state_o`=00
  - LFSR=`SEED`
  - button edge register=0
- LFSR:
  - Galois, x^16+x^14+x^13+x^11+1.
  - Advances every cycle regardless of state.
- Button edge:
  - `rise` = `btn` & ~`btn_q`.
  - Only an exactly one-hot `rise` is a valid press.
  - Multi-bit rises are ignored.
  - Presses outside WAIT_BTN are dropped, not queued.
- FSM states and transitions:
  - IDLE: on `start`=1, go to INIT.
  - INIT: clear `matrix`, latch `goal`, spawn count=2, go to SPAWN.
  - WAIT_BTN: on a valid press, register `direction`=`rise` and go to ISSUE.
  - ISSUE: `enable`=1 for exactly this cycle; `direction` held stable through WAIT; go to WAIT.
  - WAIT: count `LOGIC_LAT` cycles, then go to COMMIT.
  - COMMIT: `direction`←0.
    - If `matrix_D` != `matrix`: `matrix`←`matrix_D`, spawn count=1, go to SPAWN.
    - Otherwise go to CHECK. No spawn on a no-op move.
  - SPAWN: probe one cell per cycle.
    - Probe start index = `lfsr[3:0]` captured on entry; row=idx[3:2], col=idx[1:0].
    - Probe index increments mod 16.
    - First zero cell gets 2, or 4 if `lfsr[7:4]`==4'hF.
    - After spawn count reaches 0, go to CHECK.
    - If 16 probes find no empty cell, abort the spawn and go to CHECK.
  - CHECK: `wl`=01 → WON; `wl`=10 → LOST; otherwise WAIT_BTN.
    - `wl` is sampled in COMMIT and held for CHECK.
  - WON/LOST: board frozen, buttons ignored; `start`=1 → INIT.
- Latency:
  - Press edge to `enable`: 2 cycles (WAIT_BTN registers, ISSUE strobes).
  - Press to board update: 2+`LOGIC_LAT`+1 cycles.
  - Spawn: 1–16 cycles per tile.
- `state_o`:
  - IDLE → 00.
  - INIT, WAIT_BTN, ISSUE, WAIT, COMMIT, SPAWN, CHECK → 01.
  - WON → 10, LOST → 11.
- Reset mid-operation (any state, including ISSUE/WAIT): immediate return to reset values. `enable` must drop asynchronously.
- `start` held high in WAIT_BTN has no effect; restart only from IDLE/WON/LOST.

Decomposition:
- Package `game_2048_pkg`:
  - `TILE_W`
  - direction constants (`DIR_UP`/`DOWN`/`LEFT`/`RIGHT`/`NONE`)
  - `wl` codes (`WL_PLAY`/`WL_WIN`/`WL_LOSE`)
  - `board_t` (TILE_W x4x4)
  - controller state enum
- Sub-module `lfsr16`: ports `clk`, `rst`, `q[15:0]`; parameter `SEED`.

Test Plan:
- Reset then `start`=1 with `SEED`=16'hACE1 → two non-zero cells, each 2 or 4, at distinct positions matching a reference LFSR model; `state_o`=01.
- Preload board via a stub `game_logic` returning `matrix_D`=shifted board; press left (`btn`=0100) → `enable` high exactly one cycle with `direction`=0100, `matrix`=`matrix_D` plus exactly one new tile.
- Stub returns `matrix_D`==`matrix`; press up → no spawn, `matrix` unchanged, back in WAIT_BTN after CHECK.
- Stub returns `wl`=01 on the move → `state_o`=10; further presses produce no `enable`; `start` → fresh INIT.
- Board full, move changes the board but leaves no zero → SPAWN aborts after 16 cycles, stub `wl`=10 → `state_o`=11.
- Assert `rst` during WAIT, and separately press `btn`=0011 (two bits) → all outputs return to reset values immediately; the two-bit press generates no `enable`.
